// File: rtl/execute_stage_mc.sv
// MIPS EX stage: forwarding, stall/flush-controlled EX/MEM register,
// iterative shift-add MULTU into HI/LO with MFHI/MFLO read-back and a busy interlock.
module execute_stage_mc #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_BITS      = 32,
    parameter int unsigned REG_ADDR_BITS  = 5,
    parameter int unsigned EXEC_BUS_WIDTH = 9,
    parameter int unsigned MEM_BUS_WIDTH  = 3,
    parameter int unsigned WB_BUS_WIDTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic                      stall_in,
    input  logic                      flush_in,
    input  logic [EXEC_BUS_WIDTH-1:0] exec_bus_in,
    input  logic [MEM_BUS_WIDTH-1:0]  mem_bus_in,
    input  logic [WB_BUS_WIDTH-1:0]   wb_bus_in,
    input  logic [DATA_WIDTH-1:0]     rs_data_in,
    input  logic [DATA_WIDTH-1:0]     rt_data_in,
    input  logic [DATA_WIDTH-1:0]     imm_in,
    input  logic [DATA_WIDTH-1:0]     shamt_in,
    input  logic [REG_ADDR_BITS-1:0]  rd_addr_in,
    input  logic [REG_ADDR_BITS-1:0]  rt_addr_in,
    input  logic [ADDR_BITS-1:0]      next_pc_in,
    input  logic [1:0]                fwd_a_sel,
    input  logic [1:0]                fwd_b_sel,
    input  logic [DATA_WIDTH-1:0]     fwd_mem_data,
    input  logic [DATA_WIDTH-1:0]     fwd_wb_data,
    output logic                      valid_out,
    output logic [DATA_WIDTH-1:0]     alu_result_out,
    output logic [REG_ADDR_BITS-1:0]  reg_w_addr_out,
    output logic [MEM_BUS_WIDTH-1:0]  mem_bus_out,
    output logic [WB_BUS_WIDTH-1:0]   wb_bus_out,
    output logic [DATA_WIDTH-1:0]     rt_data_out,
    output logic [ADDR_BITS-1:0]      branch_target_out,
    output logic                      zero_out,
    output logic                      busy_out
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned SH_W   = $clog2(DATA_WIDTH);
    localparam int unsigned CNT_W  = $clog2(DATA_WIDTH);

    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_MFHI  = 2'b10;
    localparam logic [1:0] MD_MFLO  = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic                     busy_q, busy_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [PROD_W-1:0]        mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]    mplier_q, mplier_d;
    logic [PROD_W-1:0]        acc_q, acc_d;
    logic [DATA_WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;

    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;
    logic [REG_ADDR_BITS-1:0] waddr_q, waddr_d;
    logic [MEM_BUS_WIDTH-1:0] mem_q, mem_d;
    logic [WB_BUS_WIDTH-1:0]  wb_q, wb_d;
    logic [DATA_WIDTH-1:0]    rt_q, rt_d;
    logic [ADDR_BITS-1:0]     bt_q, bt_d;
    logic                     zero_q, zero_d;

    logic [3:0]               alu_op;
    logic                     alu_src, reg_dst, shamt_sel;
    logic [1:0]               md_op;
    logic [DATA_WIDTH-1:0]    op_a, op_b, alu_b, alu_res;
    logic [PROD_W-1:0]        acc_next;

    assign alu_op    = exec_bus_in[3:0];
    assign alu_src   = exec_bus_in[4];
    assign reg_dst   = exec_bus_in[5];
    assign shamt_sel = exec_bus_in[6];
    assign md_op     = exec_bus_in[8:7];

    // Operand forwarding: 01 from MEM, 10 from WB, otherwise register file.
    always_comb begin
        op_a = rs_data_in;
        op_b = rt_data_in;
        if (fwd_a_sel == 2'b01)      op_a = fwd_mem_data;
        else if (fwd_a_sel == 2'b10) op_a = fwd_wb_data;
        if (fwd_b_sel == 2'b01)      op_b = fwd_mem_data;
        else if (fwd_b_sel == 2'b10) op_b = fwd_wb_data;
        alu_b = alu_src ? imm_in : op_b;
        if (shamt_sel) alu_b = shamt_in;
    end

    // ALU; shifts move operand A by the low bits of the b input.
    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            4'h0:    alu_res = op_a & alu_b;
            4'h1:    alu_res = op_a | alu_b;
            4'h2:    alu_res = op_a + alu_b;
            4'h3:    alu_res = op_a ^ alu_b;
            4'h4:    alu_res = op_a << alu_b[SH_W-1:0];
            4'h5:    alu_res = op_a >> alu_b[SH_W-1:0];
            4'h6:    alu_res = op_a - alu_b;
            4'h7:    alu_res = DATA_WIDTH'($signed(op_a) < $signed(alu_b));
            4'h8:    alu_res = DATA_WIDTH'($signed(op_a) >>> alu_b[SH_W-1:0]);
            4'h9:    alu_res = DATA_WIDTH'(op_a < alu_b);
            4'hC:    alu_res = ~(op_a | alu_b);
            default: alu_res = '0;
        endcase
    end

    // Next-state: multiplier FSM and EX/MEM register.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_next = '0;
        valid_d  = valid_q;
        result_d = result_q;
        waddr_d  = waddr_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        rt_d     = rt_q;
        bt_d     = bt_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (valid_in && md_op == MD_MULTU && !stall_in && !flush_in) begin
                    state_d  = S_MUL;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    mcand_d  = PROD_W'(op_a);
                    mplier_d = op_b;
                    acc_d    = '0;
                end
            end
            S_MUL: begin
                if (flush_in) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        hi_d    = acc_next[PROD_W-1:DATA_WIDTH];
                        lo_d    = acc_next[DATA_WIDTH-1:0];
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (flush_in || (!stall_in && (busy_q || !valid_in))) begin
            valid_d = 1'b0;
            mem_d   = '0;
            wb_d    = '0;
        end else if (!stall_in) begin
            valid_d  = 1'b1;
            result_d = (md_op == MD_MFHI) ? hi_q :
                       (md_op == MD_MFLO) ? lo_q : alu_res;
            zero_d   = (alu_res == '0);
            waddr_d  = reg_dst ? rd_addr_in : rt_addr_in;
            mem_d    = mem_bus_in;
            wb_d     = wb_bus_in;
            rt_d     = op_b;
            bt_d     = next_pc_in + ADDR_BITS'(imm_in << 2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            waddr_q  <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            rt_q     <= '0;
            bt_q     <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            waddr_q  <= waddr_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            rt_q     <= rt_d;
            bt_q     <= bt_d;
            zero_q   <= zero_d;
        end
    end

    assign valid_out         = valid_q;
    assign alu_result_out    = result_q;
    assign reg_w_addr_out    = waddr_q;
    assign mem_bus_out       = mem_q;
    assign wb_bus_out        = wb_q;
    assign rt_data_out       = rt_q;
    assign branch_target_out = bt_q;
    assign zero_out          = zero_q;
    assign busy_out          = busy_q;

endmodule
